// File: rtl/phase_monitor.sv
// phase_monitor: tracks a four-phase clock sequence, flags illegal steps, counts cycles
//   CLK                 system clock, posedge
//   RST_N               asynchronous active-low reset
//   CLK_FT/DC/EX/WB     phase clocks sampled in the CLK domain
//   PHASE               decoded phase (0=FT,1=DC,2=EX,3=WB), 0 unless LOCK
//   LOCK                sequence tracked
//   FT/DC/EX/WB_RISE    one-cycle rising-edge strobes
//   ERR                 sticky illegal-sequence flag
//   ERR_CNT             saturating illegal-transition count (PHASE_MONITOR_ERRCNT_EN), else 0
//   CYCLE_CNT           completed instruction cycles, wraps
module phase_monitor #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             CLK_FT,
    input  logic             CLK_DC,
    input  logic             CLK_EX,
    input  logic             CLK_WB,
    output logic [1:0]       PHASE,
    output logic             LOCK,
    output logic             FT_RISE,
    output logic             DC_RISE,
    output logic             EX_RISE,
    output logic             WB_RISE,
    output logic             ERR,
    output logic [7:0]       ERR_CNT,
    output logic [CNT_W-1:0] CYCLE_CNT
);
    localparam logic [1:0] HUNT = 2'd0, START = 2'd1, LOCKED = 2'd2, ERROR = 2'd3;
    logic [3:0] smp, prev;
    logic [1:0] state, nxt, dec;
    logic legal, err_entry;
    always_comb begin
        legal = (prev == 4'b1100 && smp == 4'b0110) || (prev == 4'b0110 && smp == 4'b0011) ||
                (prev == 4'b0011 && smp == 4'b1001) || (prev == 4'b1001 && smp == 4'b1100);
        nxt = state == HUNT   ? (smp == 4'b1000 ? START : smp == 4'b1100 ? LOCKED : HUNT) :
              state == LOCKED ? (legal ? LOCKED : ERROR) :
              smp == 4'b1100  ? LOCKED : ERROR;
        dec = smp == 4'b1100 ? 2'd1 : smp == 4'b0110 ? 2'd2 : smp == 4'b0011 ? 2'd3 : 2'd0;
        err_entry = nxt == ERROR && state != ERROR;
    end
    // Everything derived from smp/prev lands one edge after sampling, aligned with the strobes.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            smp <= '0;
            prev <= '0;
            state <= HUNT;
            PHASE <= '0;
            LOCK <= 1'b0;
            {FT_RISE, DC_RISE, EX_RISE, WB_RISE} <= '0;
            ERR <= 1'b0;
            CYCLE_CNT <= '0;
        end else begin
            smp <= {CLK_FT, CLK_DC, CLK_EX, CLK_WB};
            prev <= smp;
            state <= nxt;
            LOCK <= nxt == LOCKED;
            PHASE <= nxt == LOCKED ? dec : 2'd0;
            {FT_RISE, DC_RISE, EX_RISE, WB_RISE} <= smp & ~prev;
            if (err_entry) ERR <= 1'b1;
            // WB can only be reached in LOCKED through a legal step, so this is each entry.
            if (nxt == LOCKED && smp == 4'b0011) CYCLE_CNT <= CYCLE_CNT + CNT_W'(1);
        end
    end
`ifdef PHASE_MONITOR_ERRCNT_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) ERR_CNT <= '0;
        else if (err_entry && ERR_CNT != 8'hFF) ERR_CNT <= ERR_CNT + 8'd1;
    end
`else
    assign ERR_CNT = '0;
`endif
endmodule

// File: tb/tb_phase_monitor.sv
// tb_phase_monitor: scoreboard bench for phase_monitor
module tb_phase_monitor;
`ifdef PHASE_MONITOR_ERRCNT_EN
    localparam bit ECON = 1'b1;
`else
    localparam bit ECON = 1'b0;
`endif
    typedef struct {
        int          due;
        string       tag;
        logic [35:0] v;
    } exp_rec;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [3:0] pat = 4'b0000;
    logic [3:0] prev_p = 4'b0000;
    logic rel_now = 1'b1;
    int edge_n = 0;
    int checks = 0;
    int errors = 0;
    exp_rec q[$];
    logic [1:0] phase, phase4;
    logic lock, ft_rise, dc_rise, ex_rise, wb_rise, err, lock4, r4a, r4b, r4c, r4d, err4;
    logic [7:0] err_cnt, err_cnt4;
    logic [15:0] cycle_cnt;
    logic [3:0] cycle_cnt4;
    wire [35:0] got = {ft_rise, dc_rise, ex_rise, wb_rise, lock, phase, err, err_cnt, cycle_cnt, cycle_cnt4};
    phase_monitor dut (
        .CLK(clk), .RST_N(rst_n), .CLK_FT(pat[3]), .CLK_DC(pat[2]), .CLK_EX(pat[1]), .CLK_WB(pat[0]),
        .PHASE(phase), .LOCK(lock), .FT_RISE(ft_rise), .DC_RISE(dc_rise), .EX_RISE(ex_rise),
        .WB_RISE(wb_rise), .ERR(err), .ERR_CNT(err_cnt), .CYCLE_CNT(cycle_cnt)
    );
    phase_monitor #(.CNT_W(4)) dut4 (
        .CLK(clk), .RST_N(rst_n), .CLK_FT(pat[3]), .CLK_DC(pat[2]), .CLK_EX(pat[1]), .CLK_WB(pat[0]),
        .PHASE(phase4), .LOCK(lock4), .FT_RISE(r4a), .DC_RISE(r4b), .EX_RISE(r4c),
        .WB_RISE(r4d), .ERR(err4), .ERR_CNT(err_cnt4), .CYCLE_CNT(cycle_cnt4)
    );
    always #5 clk = ~clk;
    always @(posedge clk) edge_n++;
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].due <= edge_n) begin
            exp_rec r;
            r = q.pop_front();
            checks++;
            if (r.due != edge_n || got !== r.v) begin
                errors++;
                $display("FAIL %s edge %0d due %0d got %h exp %h", r.tag, edge_n, r.due, got, r.v);
            end
        end
    end
    // Drive one generator pattern; its effect on the outputs appears two edges later.
    task automatic step(input logic [3:0] p, input logic lk, input logic [1:0] ph, input logic er,
                        input int ec, input int cc, input string tag);
        exp_rec r;
        int ecx;
        @(posedge clk);
        #1;
        pat = p;
        if (rel_now) begin
            rst_n = 1'b1;
            rel_now = 1'b0;
        end
        ecx = ECON ? (ec > 255 ? 255 : ec) : 0;
        r.due = edge_n + 2;
        r.tag = tag;
        r.v = {p & ~prev_p, lk, ph, er, 8'(ecx), 16'(cc), 4'(cc)};
        prev_p = p;
        q.push_back(r);
    endtask
    task automatic drain();
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain pending %0d exp 0", q.size());
            q.delete();
        end
    endtask
    task automatic do_reset();
        drain();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (got !== 36'd0 || lock4 !== 1'b0 || err4 !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got %h lock4 %b err4 %b exp 0", got, lock4, err4);
        end
        @(posedge clk);
        prev_p = 4'b0000;
        rel_now = 1'b1;
    endtask
    initial begin
        #100000;
        $display("FAIL timeout checks %0d", checks);
        $fatal(1);
    end
    initial begin
        step(4'b0000, 0, 0, 0, 0, 0, "hunt_idle");
        step(4'b1000, 0, 0, 0, 0, 0, "start");
        step(4'b1100, 1, 1, 0, 0, 0, "lock_dc");
        step(4'b0110, 1, 2, 0, 0, 0, "ex");
        step(4'b0011, 1, 3, 0, 0, 1, "wb_cnt");
        step(4'b1001, 1, 0, 0, 0, 1, "ft");
        step(4'b1100, 1, 1, 0, 0, 1, "dc2");
        step(4'b0110, 1, 2, 0, 0, 1, "ex2");
        step(4'b0110, 0, 0, 1, 1, 1, "hold_err");
        step(4'b0011, 0, 0, 1, 1, 1, "err_stay");
        step(4'b1100, 1, 1, 1, 1, 1, "relock");
        step(4'b0110, 1, 2, 1, 1, 1, "relock_ex");
        step(4'b0011, 1, 3, 1, 1, 2, "relock_wb");
        step(4'b1001, 1, 0, 1, 1, 2, "relock_ft");
        do_reset();
        step(4'b0011, 0, 0, 0, 0, 0, "mid_wb");
        step(4'b1001, 0, 0, 0, 0, 0, "mid_ft");
        step(4'b1100, 1, 1, 0, 0, 0, "mid_lock");
        step(4'b0110, 1, 2, 0, 0, 0, "mid_ex");
        step(4'b0011, 1, 3, 0, 0, 1, "mid_wb_cnt");
        step(4'b1001, 1, 0, 0, 0, 1, "mid_ft2");
        do_reset();
        step(4'b0000, 0, 0, 0, 0, 0, "sat_idle");
        step(4'b1100, 1, 1, 0, 0, 0, "hunt_direct_lock");
        for (int i = 1; i <= 300; i++) begin
            step(4'b0011, 0, 0, 1, i, 0, "sat_err");
            step(4'b1100, 1, 1, 1, i, 0, "sat_relock");
        end
        do_reset();
        step(4'b0000, 0, 0, 0, 0, 0, "wrap_idle");
        step(4'b1000, 0, 0, 0, 0, 0, "wrap_start");
        step(4'b1100, 1, 1, 0, 0, 0, "wrap_lock");
        for (int c = 1; c <= 17; c++) begin
            step(4'b0110, 1, 2, 0, 0, c - 1, "wrap_ex");
            step(4'b0011, 1, 3, 0, 0, c, "wrap_wb");
            step(4'b1001, 1, 0, 0, 0, c, "wrap_ft");
            step(4'b1100, 1, 1, 0, 0, c, "wrap_dc");
        end
        do_reset();
        step(4'b0000, 0, 0, 0, 0, 0, "se_idle");
        step(4'b1000, 0, 0, 0, 0, 0, "se_start");
        step(4'b0110, 0, 0, 1, 1, 0, "start_err");
        step(4'b0110, 0, 0, 1, 1, 0, "start_err_stay");
        drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/phase_monitor.md
PHASE_MONITOR -- requirements
Module: phase_monitor

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the instruction-cycle counter.
REQ-002 SHALL have ports: CLK  input  1  system clock; all logic on posedge.
REQ-003 SHALL have ports: RST_N  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: CLK_FT, CLK_DC, CLK_EX, CLK_WB  input  1 each  phase clocks from the four-phase generator, same CLK domain.
REQ-005 SHALL have ports: PHASE  output  2  decoded phase (0=FT, 1=DC, 2=EX, 3=WB), valid only while LOCK=1.
REQ-006 SHALL have ports: LOCK  output  1  phase sequence tracked.
REQ-007 SHALL have ports: FT_RISE, DC_RISE, EX_RISE, WB_RISE  output  1 each  one-cycle rising-edge strobes.
REQ-008 SHALL have ports: ERR  output  1  sticky illegal-sequence flag.
REQ-009 SHALL have ports: ERR_CNT  output  8  illegal-transition count.
REQ-010 SHALL have ports: CYCLE_CNT  output  CNT_W  completed instruction cycles.

Function
REQ-011 SHALL register the 4-bit pattern P={FT,DC,EX,WB} into SMP each posedge and copy SMP into PREV each posedge.
REQ-012 SHALL assert X_RISE for exactly one cycle when SMP.X=1 and PREV.X=0; a generator edge at CLK edge k SHALL yield a strobe high from edge k+2 to k+3.
REQ-013 SHALL implement states HUNT, START, LOCKED, ERROR, with every transition evaluated on SMP (old value: PREV).
REQ-014 HUNT: SMP=0000 stays; 1000 -> START; 1100 -> LOCKED; any other pattern stays HUNT, no error.
REQ-015 START: SMP=1100 -> LOCKED; any other pattern -> ERROR.
REQ-016 LOCKED: the only legal PREV->SMP steps SHALL be 1100->0110, 0110->0011, 0011->1001, 1001->1100; any other step, including a hold, SHALL go to ERROR.
REQ-017 ERROR: SMP=1100 -> LOCKED; otherwise stay.
REQ-018 SHALL drive LOCK=1 in LOCKED only, with PHASE from SMP: 1001->0, 1100->1, 0110->2, 0011->3; PHASE SHALL be 0 when LOCK=0.
REQ-019 SHALL set ERR on every entry into ERROR; ERR SHALL stay set until reset, including across re-lock.
REQ-020 SHALL increment ERR_CNT on each entry into ERROR and saturate at 255.
REQ-021 SHALL increment CYCLE_CNT by one on each LOCKED entry into PHASE=3 and wrap modulo 2^CNT_W.
REQ-022 SHALL register all outputs, with state, PHASE, LOCK and the counters updated on the same edge as the strobes of REQ-012.

Reset
REQ-023 RST_N=0 SHALL asynchronously force: SMP=PREV=0000, state=HUNT, PHASE=0, LOCK=0, all strobes 0, ERR=0, ERR_CNT=0, CYCLE_CNT=0.
REQ-024 Reset mid-sequence SHALL discard lock; after release, the monitor SHALL re-lock at the next sampled 1100 with no error raised.

Configuration
REQ-025 With macro PHASE_MONITOR_ERRCNT_EN defined, ERR_CNT SHALL behave per REQ-020.
REQ-026 Without PHASE_MONITOR_ERRCNT_EN, ERR_CNT SHALL be constant 0 and no counter register SHALL exist; ERR SHALL be unaffected.

Verification
REQ-027 Generator-driven stream from power-up 0000,1000,1100,0110,0011,1001 -> LOCK=1 two edges after 1100 is driven, PHASE 1,2,3,0, CYCLE_CNT=1, ERR=0.
REQ-028 Locked stream with one pattern held two cycles (0110,0110) -> ERR=1, ERR_CNT=1, LOCK=0; next 1100 -> LOCK=1 with ERR still 1.
REQ-029 Monitor reset released while the generator is mid-stream at 0011 -> no error, LOCK=1 after next 1100, CYCLE_CNT counts from 0.
REQ-030 300 injected illegal steps each followed by 1100 -> ERR_CNT=255 (saturated); without PHASE_MONITOR_ERRCNT_EN -> ERR_CNT=0, ERR=1.
REQ-031 CNT_W=4 with 17 full cycles locked -> CYCLE_CNT wraps to 1.
REQ-032 RST_N asserted mid-cycle, between CLK edges -> all outputs at reset values immediately, without waiting for a CLK edge.
